// File: rtl/sci_alu_driver_pkg.sv
// Shared types and constants for the scientific ALU driver.
// The package is named sci_alu_pkg so that the ALU shell and the driver can share it.
package sci_alu_pkg;

    localparam int DATA_W    = 64;
    localparam int OP_W      = 4;
    localparam int SETTLE_W  = 4;   // holds SETTLE_CYCLES-1; the legal range is 1..15
    localparam int TAG_MAX_W = 16;  // storage width of the tag field in the response struct

    // Opcodes with a fixed meaning. The remaining codes follow the ALU's C model.
    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3
    } sci_op_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } drv_state_t;

    typedef struct packed {
        logic [DATA_W-1:0]    result;
        logic                 exception;
        logic                 error;
        logic [TAG_MAX_W-1:0] tag;
    } sci_rsp_t;

endpackage

// File: rtl/sci_alu_driver_if.sv
// Request/response valid-ready bus between the host sequencer and sci_alu_driver.
interface sci_alu_driver_if
    import sci_alu_pkg::*;
#(
    parameter int TAG_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [OP_W-1:0]   req_op;
    logic [TAG_W-1:0]  req_tag;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_exception;
    logic              rsp_error;
    logic [TAG_W-1:0]  rsp_tag;

    // The host side issues requests and consumes responses.
    modport master (
        output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_exception, rsp_error, rsp_tag
    );

    // The driver side accepts requests and produces responses.
    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_exception, rsp_error, rsp_tag
    );
endinterface

// File: rtl/sci_alu_driver_sat_counter.sv
// Saturating up-counter with a synchronous clear, used for the exception/error statistics.
module sci_alu_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear wins over increment, and the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + W'(1);
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;
endmodule

// File: rtl/sci_alu_driver.sv
// Clocked initiator for the combinational scientific ALU. It latches one request
// onto the ALU inputs, waits SETTLE_CYCLES, captures the ALU outputs and returns
// them as a tagged response.
// Optional feature macro: SCI_ALU_DRV_STATS_EN builds the exception and error
// counters. Without it, exc_count and err_count are tied to 0.
module sci_alu_driver
    import sci_alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int TAG_W         = 4,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    sci_alu_driver_if.slave   bus,
    output logic [DATA_W-1:0] alu_a_in,
    output logic [DATA_W-1:0] alu_b_in,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_result_out,
    input  logic              alu_exception,
    input  logic              alu_error,
    output logic              busy,
    output logic [CNT_W-1:0]  exc_count,
    output logic [CNT_W-1:0]  err_count
);
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("sci_alu_driver: SETTLE_CYCLES must be in 1..15");
    end
    if (TAG_W < 1 || TAG_W > TAG_MAX_W) begin : g_bad_tag
        $error("sci_alu_driver: TAG_W must be in 1..TAG_MAX_W");
    end

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    drv_state_t         state_q, state_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    sci_rsp_t           rsp_q, rsp_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               ready_q, ready_d;
    logic               accept, rsp_hs;

    // ready_q is only ever set when the next state is IDLE, so it also qualifies the state.
    assign accept = ready_q & bus.req_valid;
    assign rsp_hs = rsp_valid_q & bus.rsp_ready;

    // Next-state logic and datapath loads for the IDLE -> SETTLE -> RESP sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        tag_d       = tag_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    op_d    = bus.req_op;
                    tag_d   = bus.req_tag;
                    cnt_d   = SETTLE_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - SETTLE_W'(1);
                end else begin
                    rsp_d.result    = alu_result_out;
                    rsp_d.exception = alu_exception;
                    rsp_d.error     = alu_error;
                    rsp_d.tag       = TAG_MAX_W'(tag_q);
                    rsp_valid_d     = 1'b1;
                    state_d         = RESP;
                end
            end
            RESP: begin
                // rsp_* fields stay put; only the valid flag drops on the handshake.
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered ready: low throughout reset and high the cycle after IDLE is re-entered.
        ready_d = (state_d == IDLE);
    end

    // State and datapath registers. A reset discards any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            tag_q       <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            tag_q       <= tag_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            ready_q     <= ready_d;
        end
    end

    assign alu_a_in          = a_q;
    assign alu_b_in          = b_q;
    assign alu_opcode        = op_q;
    assign bus.req_ready     = ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_result    = rsp_q.result;
    assign bus.rsp_exception = rsp_q.exception;
    assign bus.rsp_error     = rsp_q.error;
    assign bus.rsp_tag       = rsp_q.tag[TAG_W-1:0];
    assign busy              = (state_q != IDLE);

    // The upper tag bits exist only because the struct is sized for the widest tag.
    logic unused_tag_hi;
    assign unused_tag_hi = ^rsp_q.tag;

`ifdef SCI_ALU_DRV_STATS_EN
    // Statistics are counted when the consumer takes the response, not at capture.
    sci_alu_sat_counter #(.W(CNT_W)) u_exc_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (1'b0),
        .inc_i   (rsp_hs & rsp_q.exception),
        .count_o (exc_count)
    );
    sci_alu_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (1'b0),
        .inc_i   (rsp_hs & rsp_q.error),
        .count_o (err_count)
    );
`else
    assign exc_count = '0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_sci_alu_driver.sv
// Self-checking bench for sci_alu_driver. A stand-in ALU model supplies the ALU outputs.
// Expected responses, latencies and counter values come from a transaction queue and
// plain integer counts.
module tb_sci_alu_driver;
    import sci_alu_pkg::*;

    localparam int SETTLE = 2;
    localparam int TAG_W  = 4;
    localparam int CNT_W  = 4;   // narrow so saturation is reachable in a short run
`ifdef SCI_ALU_DRV_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sci_alu_driver_if #(.TAG_W(TAG_W)) bus();

    logic [63:0]      alu_a_in, alu_b_in, alu_result_out;
    logic [3:0]       alu_opcode;
    logic             alu_exception, alu_error, busy;
    logic [CNT_W-1:0] exc_count, err_count;

    sci_alu_driver #(.SETTLE_CYCLES(SETTLE), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .alu_a_in       (alu_a_in),
        .alu_b_in       (alu_b_in),
        .alu_opcode     (alu_opcode),
        .alu_result_out (alu_result_out),
        .alu_exception  (alu_exception),
        .alu_error      (alu_error),
        .busy           (busy),
        .exc_count      (exc_count),
        .err_count      (err_count)
    );

    // Stand-in ALU: {result, exception, error}.
    function automatic logic [65:0] alu_fn(logic [63:0] a, logic [63:0] b, logic [3:0] op);
        real ra, rb;
        logic [63:0] r;
        logic x, e;
        ra = $bitstoreal(a);
        rb = $bitstoreal(b);
        x = 1'b0;
        e = 1'b0;
        case (op)
            4'd0: r = $realtobits(ra + rb);
            4'd1: r = $realtobits(ra - rb);
            4'd2: r = $realtobits(ra * rb);
            4'd3: begin
                if (b[62:0] == 63'd0) begin r = 64'h7FF0000000000000; x = 1'b1; end
                else r = $realtobits(ra / rb);
            end
            4'hD: begin r = a ^ b; x = 1'b1; e = 1'b1; end
            4'hE: begin r = a & b; x = 1'b1; end
            4'hF: begin r = a | b; e = 1'b1; end
            default: r = a + b + {60'd0, op};
        endcase
        return {r, x, e};
    endfunction

    always_comb {alu_result_out, alu_exception, alu_error} = alu_fn(alu_a_in, alu_b_in, alu_opcode);

    typedef struct {
        logic [63:0]      a, b, res;
        logic [3:0]       op;
        logic [TAG_W-1:0] tag;
        logic             exc, err;
    } txn_t;

    txn_t pend[$];
    int checks = 0, errors = 0;
    int cyc = 0;
    int n_exc = 0, n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [CNT_W-1:0] exp_cnt(int n);
        int m;
        m = (1 << CNT_W) - 1;
        if (!STATS) return '0;
        return CNT_W'((n > m) ? m : n);
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Present a request (called just after a negedge) and wait for the accepting posedge.
    task automatic start(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                         input logic [TAG_W-1:0] tag, output int waited, output int acc);
        txn_t t;
        logic [65:0] f;
        bus.req_valid = 1'b1;
        bus.req_a = a;
        bus.req_b = b;
        bus.req_op = op;
        bus.req_tag = tag;
        waited = 0;
        while (!bus.req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_timeout", 64'(waited < 50), 64'd1);
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        bus.req_valid = 1'b0;
        f = alu_fn(a, b, op);
        t.a = a; t.b = b; t.op = op; t.tag = tag;
        t.res = f[65:2]; t.exc = f[1]; t.err = f[0];
        pend.push_back(t);
        chk("alu_a", alu_a_in, a);
        chk("alu_b", alu_b_in, b);
        chk("alu_op", 64'(alu_opcode), 64'(op));
        chk("busy_settle", 64'(busy), 64'd1);
        chk("req_ready_settle", 64'(bus.req_ready), 64'd0);
    endtask

    // Wait for the response, optionally stall it for 'hold' cycles, then take it.
    task automatic finish(input int hold);
        txn_t t;
        int lat;
        t = pend.pop_front();
        lat = 0;
        while (!bus.rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(SETTLE));
        chk("rsp_result", bus.rsp_result, t.res);
        chk("rsp_exc", 64'(bus.rsp_exception), 64'(t.exc));
        chk("rsp_err", 64'(bus.rsp_error), 64'(t.err));
        chk("rsp_tag", 64'(bus.rsp_tag), 64'(t.tag));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
            chk("hold_result", bus.rsp_result, t.res);
            chk("hold_tag", 64'(bus.rsp_tag), 64'(t.tag));
            chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
            chk("hold_alu_a", alu_a_in, t.a);
            chk("hold_alu_op", 64'(alu_opcode), 64'(t.op));
        end
        chk("exc_before_hs", 64'(exc_count), 64'(exp_cnt(n_exc)));
        chk("err_before_hs", 64'(err_count), 64'(exp_cnt(n_err)));
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        n_exc += int'(t.exc);
        n_err += int'(t.err);
        chk("rsp_valid_clr", 64'(bus.rsp_valid), 64'd0);
        chk("exc_after_hs", 64'(exc_count), 64'(exp_cnt(n_exc)));
        chk("err_after_hs", 64'(err_count), 64'(exp_cnt(n_err)));
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, acc, prev_acc;
        bus.req_valid = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_op = '0;
        bus.req_tag = '0;
        bus.rsp_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_alu_a", alu_a_in, 64'd0);
        chk("rst_rsp_result", bus.rsp_result, 64'd0);
        chk("rst_exc_count", 64'(exc_count), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.req_ready), 64'd1);

        // 1.5 + 2.0 = 3.5.
        start(64'h3FF8000000000000, 64'h4000000000000000, 4'd0, 4'd5, w, acc);
        finish(0);
        chk("add_const", bus.rsp_result, 64'h400C000000000000);
        chk("add_tag_const", 64'(bus.rsp_tag), 64'd5);

        // 1.0 / 0 raises an exception.
        start(64'h3FF0000000000000, 64'h0, 4'd3, 4'd6, w, acc);
        finish(0);
        chk("div_exc", 64'(bus.rsp_exception), 64'd1);
        chk("div_exc_count", 64'(exc_count), STATS ? 64'd1 : 64'd0);

        // Stall the response for 10 cycles while a second request waits.
        start(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 4'hD, 4'd7, w, acc);
        bus.req_valid = 1'b1;
        bus.req_a = 64'h1111;
        bus.req_b = 64'h2222;
        bus.req_op = 4'hE;
        bus.req_tag = 4'd8;
        finish(10);
        start(64'h1111, 64'h2222, 4'hE, 4'd8, w, acc);
        chk("second_accept_wait", 64'(w), 64'd0);
        finish(0);

        // Randomized operations with random stall lengths.
        for (int i = 0; i < 20; i++) begin
            start({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(4, 15)),
                  4'($urandom_range(0, 15)), w, acc);
            finish(int'($urandom_range(0, 3)));
        end

        // Reset while settling discards the operation and the statistics.
        start(64'h5555, 64'hAAAA, 4'hF, 4'd9, w, acc);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        void'(pend.pop_back());
        n_exc = 0;
        n_err = 0;
        chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(bus.req_ready), 64'd0);
        chk("midrst_alu_a", alu_a_in, 64'd0);
        chk("midrst_alu_op", 64'(alu_opcode), 64'd0);
        chk("midrst_err_count", 64'(err_count), 64'd0);
        rst_n = 1'b1;
        repeat (SETTLE + 2) begin
            @(posedge clk);
            @(negedge clk);
            chk("midrst_no_rsp", 64'(bus.rsp_valid), 64'd0);
            chk("midrst_ready_after", 64'(bus.req_ready), 64'd1);
        end
        start(64'h3FF8000000000000, 64'h4000000000000000, 4'd0, 4'd1, w, acc);
        finish(0);

        // Back-to-back at peak rate: one accept every SETTLE+2 cycles, tags in order.
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            start({$urandom, $urandom}, 64'(i), 4'd4, 4'(i), w, acc);
            if (i > 0) chk("throughput", 64'(acc - prev_acc), 64'(SETTLE + 2));
            prev_acc = acc;
            finish(0);
        end

        // Drive the error counter past saturation.
        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            start(64'(i), 64'h10, 4'hF, 4'(i), w, acc);
            finish(0);
        end
        chk("err_saturated", 64'(err_count), STATS ? 64'((1 << CNT_W) - 1) : 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
